// File: rtl/cond_logic_pipe.sv
// -----------------------------------------------------------------------------
// cond_logic_pipe
// Execute-stage conditional-execution unit. It holds the architectural NZCV
// flags and evaluates the 4-bit condition code. It gates branch, register-write
// and memory-write controls, and runs a Thumb-style IT block state machine.
// Inside an IT block, the condition of up to IT_MAX following instructions is
// taken from the stored IT state.
//
// Parameters
//   IT_MAX     max instructions covered by one IT block (1..4)
//   FLAG_INIT  NZCV value loaded on reset
// Ports
//   CLK, RESET                      clock, synchronous active-high reset
//   Valid, Stall, Flush             pipeline qualifiers for the current instr
//   PCS, RegW, MemW, NoWrite, FlagW decoder control bits
//   Cond, ALUFlags                  condition field, ALU {N,Z,C,V}
//   ITStart, ITCond, ITLen, ITPattern  IT instruction fields
//   PCSrc, RegWrite, MemWrite       gated controls (combinational)
//   CondEx                          effective condition passed (combinational)
//   Flags, InIT, ITRemaining        registered NZCV and IT state
// -----------------------------------------------------------------------------
module cond_logic_pipe #(
   parameter int         IT_MAX    = 4,
   parameter logic [3:0] FLAG_INIT = 4'b0000
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              Valid,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              PCS,
   input  logic              RegW,
   input  logic              MemW,
   input  logic              NoWrite,
   input  logic [1:0]        FlagW,
   input  logic [3:0]        Cond,
   input  logic [3:0]        ALUFlags,
   input  logic              ITStart,
   input  logic [3:0]        ITCond,
   input  logic [2:0]        ITLen,
   input  logic [IT_MAX-1:0] ITPattern,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              CondEx,
   output logic [3:0]        Flags,
   output logic              InIT,
   output logic [2:0]        ITRemaining
);

   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} it_state_t;

   localparam logic [2:0] IT_MAX_L = 3'(IT_MAX);

   it_state_t         state_r;
   logic [3:0]        flags_r;
   logic [2:0]        it_rem_r;
   logic [IT_MAX-1:0] pat_r;
   logic [3:0]        it_cond_r;

   logic              in_it_s;
   logic [3:0]        ec_s;
   logic              cond_pass_s;
   logic              adv_s;
   logic              it_accept_s;
   logic              pcsrc_s;
   logic              flag_we_s;
   logic [IT_MAX-1:0] pat_load_s;
   logic [2:0]        rem_load_s;

   // Condition-code decode against flags {N,Z,C,V}.
   function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cc)
         4'h0:    cond_eval = z;
         4'h1:    cond_eval = ~z;
         4'h2:    cond_eval = c;
         4'h3:    cond_eval = ~c;
         4'h4:    cond_eval = n;
         4'h5:    cond_eval = ~n;
         4'h6:    cond_eval = v;
         4'h7:    cond_eval = ~v;
         4'h8:    cond_eval = c & ~z;
         4'h9:    cond_eval = ~c | z;
         4'hA:    cond_eval = ~(n ^ v);
         4'hB:    cond_eval = n ^ v;
         4'hC:    cond_eval = ~z & ~(n ^ v);
         4'hD:    cond_eval = z | (n ^ v);
         4'hE:    cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   // Effective condition, advance qualifier and gated controls.
   always_comb begin
      in_it_s = (state_r == ACTIVE);
      if (in_it_s) begin
         // An else slot flips the LSB; an AL firstcond then becomes 1111 (never).
         ec_s = it_cond_r ^ {3'b000, ~pat_r[0]};
      end else begin
         ec_s = Cond;
      end
      cond_pass_s = cond_eval(ec_s, flags_r);
      adv_s       = Valid & ~Stall & ~Flush & ~RESET;
      // ITStart only acts as an IT instruction when no block is active.
      it_accept_s = ITStart & ~in_it_s;
      pcsrc_s     = adv_s & PCS & cond_pass_s & ~it_accept_s;
      flag_we_s   = adv_s & cond_pass_s & ~it_accept_s;
      RegWrite    = adv_s & RegW & cond_pass_s & ~NoWrite & ~it_accept_s;
      MemWrite    = adv_s & MemW & cond_pass_s & ~it_accept_s;
      PCSrc       = pcsrc_s;
      CondEx      = cond_pass_s;
   end

   // IT load values: pattern with slot 0 forced to "then", length clamped.
   always_comb begin
      pat_load_s    = ITPattern;
      pat_load_s[0] = 1'b1;
      if (ITLen > IT_MAX_L) begin
         rem_load_s = IT_MAX_L;
      end else begin
         rem_load_s = ITLen;
      end
   end

   // Flag register and IT block state machine.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         flags_r   <= FLAG_INIT;
         state_r   <= IDLE;
         it_rem_r  <= 3'd0;
         pat_r     <= '0;
         it_cond_r <= 4'h0;
      end else begin
         if (flag_we_s) begin
            if (FlagW[1]) flags_r[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags_r[1:0] <= ALUFlags[1:0];
         end
         if (Flush) begin
            state_r  <= IDLE;
            it_rem_r <= 3'd0;
            pat_r    <= '0;
         end else if (adv_s) begin
            case (state_r)
               IDLE: begin
                  if (ITStart && (ITLen != 3'd0)) begin
                     state_r   <= ACTIVE;
                     it_rem_r  <= rem_load_s;
                     pat_r     <= pat_load_s;
                     it_cond_r <= ITCond;
                  end
               end
               ACTIVE: begin
                  // Every advancing slot is consumed; a taken branch ends the block.
                  if (pcsrc_s || (it_rem_r == 3'd1)) begin
                     state_r  <= IDLE;
                     it_rem_r <= 3'd0;
                     pat_r    <= '0;
                  end else begin
                     it_rem_r <= it_rem_r - 3'd1;
                     pat_r    <= pat_r >> 1;
                  end
               end
               default: begin
                  state_r  <= IDLE;
                  it_rem_r <= 3'd0;
                  pat_r    <= '0;
               end
            endcase
         end
      end
   end

   assign Flags       = flags_r;
   assign InIT        = (state_r == ACTIVE);
   assign ITRemaining = it_rem_r;

endmodule

// File: tb/tb_cond_logic_pipe.sv
module tb_cond_logic_pipe;

   logic       CLK = 1'b0;
   logic       RESET, Valid, Stall, Flush, PCS, RegW, MemW, NoWrite, ITStart;
   logic [1:0] FlagW;
   logic [3:0] Cond, ALUFlags, ITCond, ITPattern;
   logic [2:0] ITLen;
   logic       PCSrc, RegWrite, MemWrite, CondEx, InIT;
   logic [3:0] Flags;
   logic [2:0] ITRemaining;

   int n_chk = 0;
   int n_bad = 0;

   cond_logic_pipe #(.IT_MAX(4), .FLAG_INIT(4'b0000)) dut (
      .CLK(CLK), .RESET(RESET), .Valid(Valid), .Stall(Stall), .Flush(Flush),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
      .Cond(Cond), .ALUFlags(ALUFlags), .ITStart(ITStart), .ITCond(ITCond),
      .ITLen(ITLen), .ITPattern(ITPattern), .PCSrc(PCSrc), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags), .InIT(InIT),
      .ITRemaining(ITRemaining)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      Valid = 1'b0; Stall = 1'b0; Flush = 1'b0; PCS = 1'b0; RegW = 1'b0;
      MemW = 1'b0; NoWrite = 1'b0; FlagW = 2'b00; Cond = 4'hE; ALUFlags = 4'h0;
      ITStart = 1'b0; ITCond = 4'h0; ITLen = 3'd0; ITPattern = 4'b0000;
   endtask

   // Plain instruction with RegW and the given condition.
   task automatic instr(input logic [3:0] cc, input logic pcs);
      idle_in();
      Valid = 1'b1; RegW = 1'b1; PCS = pcs; Cond = cc;
   endtask

   task automatic it_instr(input logic [3:0] cc, input logic [2:0] len, input logic [3:0] pat);
      idle_in();
      Valid = 1'b1; ITStart = 1'b1; ITCond = cc; ITLen = len; ITPattern = pat;
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; FlagW = 2'b11; Cond = 4'hE;
   endtask

   // Condition decode table at flags N=1 Z=1 C=0 V=0.
   logic [3:0] dec_cc [6]  = '{4'h4, 4'hA, 4'hB, 4'hD, 4'h8, 4'hF};
   logic       dec_exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      idle_in();
      RESET = 1'b1;
      tick();
      Valid = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
      #1;
      check("rst_gate", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h00);
      tick();
      check("rst_flags", {4'h0, Flags}, 8'h00);
      check("rst_init", {4'h0, InIT, ITRemaining}, 8'h00);
      RESET = 1'b0;

      // ADDS AL with Z result
      instr(4'hE, 1'b0); FlagW = 2'b11; ALUFlags = 4'b0100;
      #1;
      check("adds_rw", {7'b0, RegWrite}, 8'h01);
      tick();
      check("adds_flags", {4'h0, Flags}, 8'h04);
      instr(4'h0, 1'b0);
      #1;
      check("moveq", {6'b0, CondEx, RegWrite}, 8'h03);
      tick();
      instr(4'h1, 1'b0);
      #1;
      check("movne", {6'b0, CondEx, RegWrite}, 8'h00);
      tick();
      check("movne_flags", {4'h0, Flags}, 8'h04);

      // MemWrite and NoWrite
      instr(4'hE, 1'b0); MemW = 1'b1; NoWrite = 1'b1;
      #1;
      check("nowrite", {6'b0, MemWrite, RegWrite}, 8'h02);

      // Partial flag update
      instr(4'hE, 1'b0); FlagW = 2'b11; ALUFlags = 4'b0000;
      tick();
      instr(4'hE, 1'b0); FlagW = 2'b10; ALUFlags = 4'b1111;
      tick();
      check("flagw_nz", {4'h0, Flags}, 8'h0C);
      instr(4'h1, 1'b0); FlagW = 2'b11; ALUFlags = 4'b0000;
      tick();
      check("ne_fail_flags", {4'h0, Flags}, 8'h0C);

      for (int i = 0; i < 6; i++) begin
         instr(dec_cc[i], 1'b0);
         #1;
         check($sformatf("decode_%0h", dec_cc[i]), {7'b0, CondEx}, {7'b0, dec_exp[i]});
      end

      // IT EQ, len 3, then/else/then, Z=1
      it_instr(4'h0, 3'd3, 4'b0101);
      #1;
      check("it_cycle_gate", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h00);
      tick();
      check("it_load", {4'h0, InIT, ITRemaining}, 8'h0B);
      check("it_noflags", {4'h0, Flags}, 8'h0C);
      instr(4'h1, 1'b0);
      #1;
      check("slot1_rw", {7'b0, RegWrite}, 8'h01);
      tick();
      check("slot1_rem", {5'b0, ITRemaining}, 8'h02);
      Stall = 1'b1;
      #1;
      check("stall_gate", {7'b0, RegWrite}, 8'h00);
      tick(); tick();
      check("stall_rem", {4'h0, InIT, ITRemaining}, 8'h0A);
      Stall = 1'b0; Valid = 1'b0;
      #1;
      check("bubble_gate", {7'b0, RegWrite}, 8'h00);
      tick();
      check("bubble_rem", {4'h0, InIT, ITRemaining}, 8'h0A);
      Valid = 1'b1;
      #1;
      check("slot2_else", {6'b0, CondEx, RegWrite}, 8'h00);
      tick();
      check("slot2_rem", {5'b0, ITRemaining}, 8'h01);
      #1;
      check("slot3_rw", {7'b0, RegWrite}, 8'h01);
      tick();
      check("it_end", {4'h0, InIT, ITRemaining}, 8'h00);
      #1;
      check("post_it_cond", {7'b0, RegWrite}, 8'h00);
      tick();

      // Taken branch in slot 2 of 4
      it_instr(4'h0, 3'd4, 4'b1111);
      tick();
      check("br_load", {4'h0, InIT, ITRemaining}, 8'h0C);
      instr(4'h0, 1'b0);
      tick();
      instr(4'h0, 1'b1);
      #1;
      check("br_pcsrc", {7'b0, PCSrc}, 8'h01);
      tick();
      check("br_exit", {4'h0, InIT, ITRemaining}, 8'h00);
      instr(4'h1, 1'b0);
      #1;
      check("br_next", {6'b0, CondEx, RegWrite}, 8'h00);
      tick();

      // Flush in slot 1
      it_instr(4'h0, 3'd4, 4'b1111);
      tick();
      instr(4'h0, 1'b1); Flush = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
      #1;
      check("flush_gate", {6'b0, PCSrc, RegWrite}, 8'h00);
      tick();
      check("flush_exit", {4'h0, InIT, ITRemaining}, 8'h00);
      check("flush_flags", {4'h0, Flags}, 8'h0C);

      // AL firstcond with an else slot
      it_instr(4'hE, 3'd2, 4'b0001);
      tick();
      instr(4'h0, 1'b0);
      #1;
      check("al_then", {6'b0, CondEx, RegWrite}, 8'h03);
      tick();
      #1;
      check("al_else", {6'b0, CondEx, RegWrite}, 8'h00);
      tick();
      check("al_exit", {7'b0, InIT}, 8'h00);

      // RESET in slot 2
      it_instr(4'h0, 3'd4, 4'b1111);
      tick();
      instr(4'h0, 1'b0);
      tick();
      RESET = 1'b1;
      #1;
      check("rst_mid_gate", {7'b0, RegWrite}, 8'h00);
      tick();
      check("rst_mid_state", {Flags, InIT, ITRemaining}, 8'h00);
      RESET = 1'b0;
      instr(4'h1, 1'b0);
      #1;
      check("rst_next_cond", {7'b0, RegWrite}, 8'h01);
      tick();

      // ITStart with ITLen=0 is a no-op
      it_instr(4'h0, 3'd0, 4'b1111);
      #1;
      check("itlen0_gate", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h00);
      tick();
      check("itlen0_idle", {4'h0, InIT, ITRemaining}, 8'h00);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
